gray_serial_codec: RTL and testbench

GRAY_SERIAL_CODEC -- requirements
Module: gray_serial_codec

---
 rtl/gray_serial_codec_if.sv | 27 ++
 rtl/gray_serial_codec.sv | 161 ++++++++++++++++
 tb/tb_gray_serial_codec.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_serial_codec_if.sv
// Bus bundle for the serial Gray/binary codec: serial bit input side,
// parallel word output side and the framing-error pulse.
interface gray_serial_codec_if #(
    parameter int W = 16
);
    logic         s_valid;
    logic         s_bit;
    logic         s_first;
    logic         k;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    logic         err_frame;

    // Codec side: consumes serial bits, produces parallel words.
    modport slave (
        input  s_valid, s_bit, s_first, k, m_ready,
        output s_ready, m_valid, m_data, err_frame
    );

    // Environment side: sends serial bits, consumes parallel words.
    modport master (
        output s_valid, s_bit, s_first, k, m_ready,
        input  s_ready, m_valid, m_data, err_frame
    );
endinterface

// File: rtl/gray_serial_codec.sv
// Serial-in, parallel-out Gray<->binary converter. Bits arrive MSB first,
// are converted on the fly, assembled into a W-bit word and handed to a
// one-entry output buffer. A completed word that cannot enter the buffer
// is held while the serial input is stalled.
module gray_serial_codec #(
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_serial_codec_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STALL = 2'd2
    } state_t;

    // Index of the final bit of a word, as seen by the bit counter.
    localparam logic [5:0] LAST_CNT = 6'(W - 1);

    state_t       state_reg, state_next;
    logic [5:0]   cnt_reg, cnt_next;
    logic         prev_reg, prev_next;
    logic         mode_reg, mode_next;
    logic [W-1:0] asm_reg, asm_next;
    logic [W-1:0] data_reg, data_next;
    logic         valid_reg, valid_next;
    logic         err_reg, err_next;

    logic         accept;
    logic         drain;
    logic         bit_out;
    logic [W-1:0] word_full;
    logic         start_word;

    assign bus.s_ready   = (state_reg != STALL);
    assign bus.m_valid   = valid_reg;
    assign bus.m_data    = data_reg;
    assign bus.err_frame = err_reg;

    assign accept    = bus.s_valid && (state_reg != STALL);
    assign drain     = valid_reg && bus.m_ready;
    // Both conversion directions xor the incoming bit with prev; they only
    // differ in what is remembered as prev for the next bit.
    assign bit_out   = bus.s_bit ^ prev_reg;
    assign word_full = {asm_reg[W-2:0], bit_out};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: counter, conversion history, assembly and output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            prev_reg  <= 1'b0;
            mode_reg  <= 1'b0;
            asm_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            prev_reg  <= prev_next;
            mode_reg  <= mode_next;
            asm_reg   <= asm_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        prev_next  = prev_reg;
        mode_next  = mode_reg;
        asm_next   = asm_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        err_next   = 1'b0;
        start_word = 1'b0;

        // A drained buffer empties unless a new word loads below.
        if (drain) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (bus.s_first) begin
                        start_word = 1'b1;
                    end else begin
                        // A bit outside any word is dropped and flagged.
                        err_next = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (accept) begin
                    if (bus.s_first) begin
                        // Unexpected word start: abandon the partial word.
                        err_next   = 1'b1;
                        start_word = 1'b1;
                    end else begin
                        prev_next = mode_reg ? bit_out : bus.s_bit;
                        if (cnt_reg == LAST_CNT) begin
                            cnt_next = '0;
                            if (!valid_reg || bus.m_ready) begin
                                data_next  = word_full;
                                valid_next = 1'b1;
                                asm_next   = '0;
                                state_next = IDLE;
                            end else begin
                                asm_next   = word_full;
                                state_next = STALL;
                            end
                        end else begin
                            cnt_next = cnt_reg + 6'd1;
                            asm_next = word_full;
                        end
                    end
                end
            end

            STALL: begin
                // The held word moves in as the buffer drains.
                if (drain) begin
                    data_next  = asm_reg;
                    valid_next = 1'b1;
                    asm_next   = '0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // First bit of a word: prev is implicitly 0, so the converted bit
        // equals the input bit and becomes prev in either mode.
        if (start_word) begin
            state_next = SHIFT;
            mode_next  = bus.k;
            cnt_next   = 6'd1;
            prev_next  = bus.s_bit;
            asm_next   = {{(W-1){1'b0}}, bus.s_bit};
        end
    end

endmodule

// File: tb/tb_gray_serial_codec.sv
// Randomised scoreboard bench for gray_serial_codec: the driver pushes the
// expected converted word when a word's last bit is accepted, and a monitor
// pops and compares whenever an output word is handed over.
module tb_gray_serial_codec;

    localparam int W = 16;

    logic clk;
    logic rst_n;

    gray_serial_codec_if #(.W(W)) intf ();

    gray_serial_codec #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference conversion from the arithmetic definition of Gray code.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input bit kk);
        logic [W-1:0] r;
        if (kk) begin
            r = v;
            for (int s = 1; s < W; s++) r = r ^ (v >> s);
        end else begin
            r = v ^ (v >> 1);
        end
        return r;
    endfunction

    // Monitor: a handshake seen between edges completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && intf.m_valid && intf.m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {16'h0, intf.m_data}, 32'hFFFF_FFFF);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                $display("word out: got %h expected %h", intf.m_data, e);
                check("m_data", {16'h0, intf.m_data}, {16'h0, e});
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #1;
        if (rand_ready) intf.m_ready = 1'($urandom);
    endtask

    task automatic idle_cycle();
        intf.s_valid = 1'b0;
        after_edge();
    endtask

    // Present one bit until accepted; returns the number of edges waited.
    task automatic send_bit(input bit b, input bit first, input bit kk, output int n);
        bit acc;
        bit done;
        intf.s_valid = 1'b1;
        intf.s_bit   = b;
        intf.s_first = first;
        intf.k       = kk;
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            acc = intf.s_ready;
            after_edge();
            n++;
            if (acc) done = 1'b1;
        end
        intf.s_valid = 1'b0;
        intf.s_first = 1'b0;
        if (!done) check("s_ready_timeout", 32'd0, 32'd1);
    endtask

    // Send a full word; err_exp is the err_frame value expected after its first bit.
    task automatic send_word(input logic [W-1:0] v, input bit kk, input bit gaps,
                             input bit err_exp, output int cycles);
        int n;
        cycles = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) idle_cycle();
            end
            send_bit(v[i], (i == W - 1), kk, n);
            cycles += n;
            if (i == W - 1) check("err_first_bit", {31'h0, intf.err_frame}, {31'h0, err_exp});
            if (i == W - 2) check("err_cleared", {31'h0, intf.err_frame}, 32'd0);
        end
        exp_q.push_back(model(v, kk));
    endtask

    task automatic drain();
        int n;
        intf.m_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            after_edge();
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        after_edge();
        check("m_valid_after_drain", {31'h0, intf.m_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, {31'h0, intf.m_valid}, 32'd0);
        check({tag, "_s_ready"}, {31'h0, intf.s_ready}, 32'd1);
        check({tag, "_err"}, {31'h0, intf.err_frame}, 32'd0);
        check({tag, "_m_data"}, {16'h0, intf.m_data}, 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic [W-1:0] v;
        bit kk;

        rst_n        = 1'b0;
        intf.s_valid = 1'b0;
        intf.s_bit   = 1'b0;
        intf.s_first = 1'b0;
        intf.k       = 1'b0;
        intf.m_ready = 1'b0;

        @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Release between edges; the first bit must be taken on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1, 1'b1, 1'b1, n);
        check("first_edge_accept", n, 32'd1);
        for (int i = W - 2; i >= 0; i--) send_bit(1'(i == W - 2), 1'b0, 1'b1, n);
        exp_q.push_back(16'h8000);
        // Gray 0xC000 with k=1: word visible one cycle after the last bit.
        check("latency_m_valid", {31'h0, intf.m_valid}, 32'd1);
        check("latency_m_data", {16'h0, intf.m_data}, 32'h8000);
        drain();

        // Back-to-back with m_ready high: no lost cycles between words.
        intf.m_ready = 1'b1;
        send_word(16'hFFFF, 1'b1, 1'b0, 1'b0, cyc);
        check("b2b_cycles_1", cyc, W);
        check("b2b_valid_1", {31'h0, intf.m_valid}, 32'd1);
        send_word(16'hFFFF, 1'b0, 1'b0, 1'b0, cyc);
        check("b2b_cycles_2", cyc, W);
        check("b2b_valid_2", {31'h0, intf.m_valid}, 32'd1);
        drain();

        // Backpressure: second word completes into the stall.
        intf.m_ready = 1'b0;
        send_word(16'h0005, 1'b0, 1'b0, 1'b0, cyc);
        send_word(16'h0003, 1'b0, 1'b0, 1'b0, cyc);
        check("stall_s_ready", {31'h0, intf.s_ready}, 32'd0);
        check("stall_held_data", {16'h0, intf.m_data}, 32'h0007);
        drain();

        // Restart on bit 9: partial dropped, error pulsed, new word correct.
        intf.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0), 1'b0, n);
        send_word(16'h1234, 1'b1, 1'b0, 1'b1, cyc);
        drain();

        // Stray bit in IDLE: flagged, state stays IDLE so the next word is clean.
        send_bit(1'b1, 1'b0, 1'b0, n);
        check("stray_err", {31'h0, intf.err_frame}, 32'd1);
        check("stray_s_ready", {31'h0, intf.s_ready}, 32'd1);
        send_word(16'hA5C3, 1'b0, 1'b0, 1'b0, cyc);
        drain();

        // Asynchronous reset mid-word.
        for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0), 1'b1, n);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midword");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_word(16'h0F0F, 1'b1, 1'b0, 1'b0, cyc);
        drain();

        // Asynchronous reset while stalled with a buffered and a held word.
        intf.m_ready = 1'b0;
        send_word(16'h1111, 1'b0, 1'b0, 1'b0, cyc);
        send_word(16'h2222, 1'b1, 1'b0, 1'b0, cyc);
        check("pre_rst_stall", {31'h0, intf.s_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_stall");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        intf.m_ready = 1'b1;
        send_word(16'h8001, 1'b0, 1'b0, 1'b0, cyc);
        drain();

        // Randomised traffic with gaps, random backpressure and framing errors.
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int r;
            bit err_exp;
            err_exp = 1'b0;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_bit(1'($urandom), 1'b0, 1'($urandom), n);
                check("rand_stray_err", {31'h0, intf.err_frame}, 32'd1);
            end else if (r == 1) begin
                int len;
                len = $urandom_range(1, W - 1);
                kk = 1'($urandom);
                for (int i = 0; i < len; i++) send_bit(1'($urandom), (i == 0), kk, n);
                err_exp = 1'b1;
            end
            v  = W'($urandom);
            kk = 1'($urandom);
            send_word(v, kk, 1'b1, err_exp, cyc);
        end
        rand_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
